// File: rtl/ram32x4_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port 32x4 RAM with registered address.
// Optional power-up clear of the whole RAM: define RAM32X4_ARBITER_CLEAR_ON_RESET_EN.
module ram32x4_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy
);

  typedef enum logic {CLEAR, ARB} state_t;

`ifdef RAM32X4_ARBITER_CLEAR_ON_RESET_EN
  localparam state_t RESET_STATE = CLEAR;
`else
  localparam state_t RESET_STATE = ARB;
`endif

  state_t            state, state_next;
  logic              ptr_b, ptr_b_next;       // 0: A has priority on a tie
  logic [ADDR_W-1:0] clr_addr, clr_addr_next;
  logic              tag_valid, tag_valid_next;
  logic              tag_owner_b, tag_owner_b_next;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= RESET_STATE;
      ptr_b       <= 1'b0;
      clr_addr    <= '0;
      tag_valid   <= 1'b0;
      tag_owner_b <= 1'b0;
    end else begin
      state       <= state_next;
      ptr_b       <= ptr_b_next;
      clr_addr    <= clr_addr_next;
      tag_valid   <= tag_valid_next;
      tag_owner_b <= tag_owner_b_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next       = state;
    ptr_b_next       = ptr_b;
    clr_addr_next    = clr_addr;
    tag_valid_next   = 1'b0;
    tag_owner_b_next = tag_owner_b;
    gnt_a            = 1'b0;
    gnt_b            = 1'b0;
    ram_wren         = 1'b0;
    ram_address      = '0;
    ram_data         = '0;
    // Reset is asynchronous, so grants and RAM strobes must drop within the same cycle.
    if (!reset) begin
      unique case (state)
        CLEAR: begin
          ram_wren      = 1'b1;
          ram_address   = clr_addr;
          clr_addr_next = clr_addr + 1'b1;
          if (clr_addr == '1) state_next = ARB;
        end
        ARB: begin
          gnt_a = req_a && (!req_b || !ptr_b);
          gnt_b = req_b && !gnt_a;
          if (gnt_a) begin
            ram_wren         = we_a;
            ram_address      = addr_a;
            ram_data         = wdata_a;
            tag_valid_next   = !we_a;
            tag_owner_b_next = 1'b0;
            ptr_b_next       = 1'b1;
          end else if (gnt_b) begin
            ram_wren         = we_b;
            ram_address      = addr_b;
            ram_data         = wdata_b;
            tag_valid_next   = !we_b;
            tag_owner_b_next = 1'b1;
            ptr_b_next       = 1'b0;
          end
        end
        default: state_next = ARB;
      endcase
    end
  end

  // RAM q reflects the address registered at the grant edge, so the tag lines it up with its owner.
  assign rvalid_a = tag_valid && !tag_owner_b;
  assign rvalid_b = tag_valid && tag_owner_b;
  assign rdata_a  = rvalid_a ? ram_q : '0;
  assign rdata_b  = rvalid_b ? ram_q : '0;

`ifdef RAM32X4_ARBITER_CLEAR_ON_RESET_EN
  assign busy = (state == CLEAR);
`else
  assign busy = 1'b0;
`endif

endmodule
